// File: rtl/databus_reader.sv
// databus_reader: single RAM read on the shared 8-bit data bus with fixed access latency.
// Optional macro DATABUSREADER_BITSEL_EN enables the latched bit-select; otherwise BitData is bit 0.
module databus_reader #(
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic       DATABUSREADER_Clk,
  input  logic       DATABUSREADER_Reset,
  input  logic       DATABUSREADER_ReadReq,
  input  logic [2:0] DATABUSREADER_BitSel,
  input  logic       DATABUSREADER_BusDriven,
  input  logic [7:0] DATABUSREADER_RAMData,
  output logic       DATABUSREADER_RAMReadEnable,
  output logic       DATABUSREADER_Busy,
  output logic [7:0] DATABUSREADER_WordData,
  output logic       DATABUSREADER_BitData,
  output logic       DATABUSREADER_Valid,
  output logic       DATABUSREADER_Error
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              ren_q, ren_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              bit_q, bit_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic              sel_bit;

`ifdef DATABUSREADER_BITSEL_EN
  assign sel_bit = DATABUSREADER_RAMData[sel_q];
`else
  // Fixed bit-0 extraction, matching the writer's insertion point; no select latch.
  logic unused_bitsel;
  assign unused_bitsel = ^{DATABUSREADER_BitSel, sel_q};
  assign sel_bit       = DATABUSREADER_RAMData[0];
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ren_d   = ren_q;
    word_d  = word_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DATABUSREADER_ReadReq) begin
          if (DATABUSREADER_BusDriven) begin
            error_d = 1'b1;
          end else begin
`ifdef DATABUSREADER_BITSEL_EN
            sel_d   = DATABUSREADER_BitSel;
`endif
            cnt_d   = CNT_W'(RAM_LATENCY - 1);
            ren_d   = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (DATABUSREADER_BusDriven) begin
          // Writer owns the bus: abort without touching the captured word.
          error_d = 1'b1;
          ren_d   = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          word_d  = DATABUSREADER_RAMData;
          bit_d   = sel_bit;
          valid_d = 1'b1;
          ren_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ren_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any capture or abort.
  always_ff @(posedge DATABUSREADER_Clk) begin
    if (DATABUSREADER_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ren_q   <= 1'b0;
      word_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ren_q   <= ren_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign DATABUSREADER_RAMReadEnable = ren_q;
  assign DATABUSREADER_Busy          = (state_q != S_IDLE);
  assign DATABUSREADER_WordData      = word_q;
  assign DATABUSREADER_BitData       = bit_q;
  assign DATABUSREADER_Valid         = valid_q;
  assign DATABUSREADER_Error         = error_q;

endmodule
